fetch_decode_execute: RTL and testbench

- Front half of the team's 5-stage LEGv8-subset pipeline, combining the fetch, decode and execute stages.
- Holds the PC, instruction memory and register file.
- Decodes each instruction into control signals and computes the ALU result and branch target.
- Feeds the memory stage; receives register write-back from the write-back stage and the branch decision (pc_src) from the memory stage.

---
 rtl/fetch_decode_execute.sv | 213 +++++++++++++++++++++
 tb/tb_fetch_decode_execute.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_execute.sv
// Fetch, decode and execute stages of the LEGv8-subset pipeline.
// Holds PC, instruction memory and register file; all outputs are combinational.
module fetch_decode_execute #(
    parameter int WORD       = 64,
    parameter int INSTR_LEN  = 32,
    parameter int IMEM_DEPTH = 64,
    localparam int AW        = $clog2(IMEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pc_src,
    input  logic                 imem_we,
    input  logic [AW-1:0]        imem_addr,
    input  logic [INSTR_LEN-1:0] imem_wdata,
    input  logic [WORD-1:0]      write_data,
    input  logic [4:0]           write_register_in,
    input  logic                 reg_write_in,
    output logic [WORD-1:0]      cur_pc,
    output logic [INSTR_LEN-1:0] instruction,
    output logic [4:0]           write_register_out,
    output logic                 reg_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic                 branch,
    output logic                 uncond_branch,
    output logic                 alu_src,
    output logic [1:0]           alu_op,
    output logic [WORD-1:0]      read_data2,
    output logic [WORD-1:0]      alu_result,
    output logic                 zero,
    output logic [WORD-1:0]      branch_target
);

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [4:0]  XZR     = 5'd31;

    logic [WORD-1:0]      pc_q;
    logic [INSTR_LEN-1:0] imem [IMEM_DEPTH];
    logic [WORD-1:0]      regs [32];

    logic [INSTR_LEN-1:0] instr;
    logic                 in_range;
    logic [10:0]          opcode;
    logic                 is_add;
    logic                 is_sub;
    logic                 is_and;
    logic                 is_orr;
    logic                 is_rtype;
    logic                 is_ldur;
    logic                 is_stur;
    logic                 is_cbz;
    logic                 is_b;

    logic [4:0]           rn;
    logic [4:0]           rm;
    logic [WORD-1:0]      read_data1;
    logic [WORD-1:0]      rd2;
    logic [WORD-1:0]      sign_ext;
    logic [WORD-1:0]      alu_b;
    logic [WORD-1:0]      result;

    // PC: async clear, then sequential PC+4 or taken branch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
        end else if (pc_src) begin
            pc_q <= branch_target;
        end else begin
            pc_q <= pc_q + WORD'(4);
        end
    end

    // Instruction memory load port; contents survive reset
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_addr] <= imem_wdata;
        end
    end

    // Fetch: fetches beyond the memory return 0, which decodes as a NOP
    always_comb begin
        in_range = (pc_q[WORD-1:AW+2] == '0);
        instr    = '0;
        if (in_range) begin
            instr = imem[pc_q[AW+1:2]];
        end
    end

    // Register file: reset loads X[i] = i; XZR is never written
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (i == 31) ? '0 : WORD'(i);
            end
        end else if (reg_write_in && write_register_in != XZR) begin
            regs[write_register_in] <= write_data;
        end
    end

    // Opcode classification
    always_comb begin
        opcode   = instr[31:21];
        is_add   = (opcode == OP_ADD);
        is_sub   = (opcode == OP_SUB);
        is_and   = (opcode == OP_AND);
        is_orr   = (opcode == OP_ORR);
        is_rtype = is_add | is_sub | is_and | is_orr;
        is_ldur  = (opcode == OP_LDUR);
        is_stur  = (opcode == OP_STUR);
        is_cbz   = (instr[31:24] == OP_CBZ);
        is_b     = (instr[31:26] == OP_B);
    end

    // Control decode; unknown opcodes leave every control low
    always_comb begin
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        branch        = 1'b0;
        uncond_branch = 1'b0;
        alu_src       = 1'b0;
        alu_op        = 2'b00;
        if (is_rtype) begin
            reg_write = 1'b1;
            alu_op    = 2'b10;
        end else if (is_ldur) begin
            alu_src    = 1'b1;
            mem_read   = 1'b1;
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
        end else if (is_stur) begin
            alu_src   = 1'b1;
            mem_write = 1'b1;
        end else if (is_cbz) begin
            branch = 1'b1;
            alu_op = 2'b01;
        end else if (is_b) begin
            uncond_branch = 1'b1;
        end
    end

    // Register reads with write-through from the write-back stage
    always_comb begin
        rn = instr[9:5];
        rm = instr[28] ? instr[4:0] : instr[20:16];
        if (rn == XZR) begin
            read_data1 = '0;
        end else if (reg_write_in && write_register_in == rn) begin
            read_data1 = write_data;
        end else begin
            read_data1 = regs[rn];
        end
        if (rm == XZR) begin
            rd2 = '0;
        end else if (reg_write_in && write_register_in == rm) begin
            rd2 = write_data;
        end else begin
            rd2 = regs[rm];
        end
    end

    // Immediate extraction per instruction format
    always_comb begin
        sign_ext = '0;
        if (is_ldur || is_stur) begin
            sign_ext = {{(WORD-9){instr[20]}}, instr[20:12]};
        end else if (is_cbz) begin
            sign_ext = {{(WORD-19){instr[23]}}, instr[23:5]};
        end else if (is_b) begin
            sign_ext = {{(WORD-26){instr[25]}}, instr[25:0]};
        end
    end

    // ALU: address add, operand pass-through for CBZ, or R-type function
    always_comb begin
        alu_b  = alu_src ? sign_ext : rd2;
        result = read_data1 + alu_b;
        case (alu_op)
            2'b01: result = alu_b;
            2'b10: begin
                if (is_sub) begin
                    result = read_data1 - alu_b;
                end else if (is_and) begin
                    result = read_data1 & alu_b;
                end else if (is_orr) begin
                    result = read_data1 | alu_b;
                end
            end
            default: result = read_data1 + alu_b;
        endcase
    end

    // Output assembly
    always_comb begin
        cur_pc             = pc_q;
        instruction        = instr;
        write_register_out = instr[4:0];
        read_data2         = rd2;
        alu_result         = result;
        zero               = (result == '0);
        branch_target      = pc_q + (sign_ext << 2);
    end

endmodule

// File: tb/tb_fetch_decode_execute.sv
// Directed bench for fetch_decode_execute.
// Vector table walks a program; hand sequences cover branches, write-back and reset.
module tb_fetch_decode_execute;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_src;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [63:0] write_data;
    logic [4:0]  write_register_in;
    logic        reg_write_in;
    logic [63:0] cur_pc;
    logic [31:0] instruction;
    logic [4:0]  write_register_out;
    logic        reg_write, mem_read, mem_write, mem_to_reg;
    logic        branch, uncond_branch, alu_src;
    logic [1:0]  alu_op;
    logic [63:0] read_data2, alu_result, branch_target;
    logic        zero;

    int checks = 0;
    int errors = 0;

    fetch_decode_execute dut (
        .clk(clk), .reset(reset), .pc_src(pc_src),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .write_data(write_data), .write_register_in(write_register_in),
        .reg_write_in(reg_write_in), .cur_pc(cur_pc), .instruction(instruction),
        .write_register_out(write_register_out), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .branch(branch), .uncond_branch(uncond_branch), .alu_src(alu_src),
        .alu_op(alu_op), .read_data2(read_data2), .alu_result(alu_result),
        .zero(zero), .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [6:0]  ctrl;
        logic [1:0]  op;
        logic [4:0]  wr;
        logic [63:0] rd2;
        logic [63:0] alu;
        logic        z;
        logic [63:0] bt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int addr, input logic [31:0] data);
        imem_we    = 1'b1;
        imem_addr  = 6'(addr);
        imem_wdata = data;
        step();
        imem_we = 1'b0;
    endtask

    function automatic logic [6:0] ctrl_now();
        return {reg_write, mem_read, mem_write, mem_to_reg,
                branch, uncond_branch, alu_src};
    endfunction

    initial begin
        // ctrl = {reg_write, mem_read, mem_write, mem_to_reg, branch, uncond, alu_src}
        vecs[0]  = '{32'h8B020023, 64'd0,  7'b1000000, 2'b10, 5'd3,  64'd2,  64'd3,  1'b0, 64'd0};
        vecs[1]  = '{32'hF8408045, 64'd4,  7'b1101001, 2'b00, 5'd5,  64'd5,  64'd10, 1'b0, 64'd36};
        vecs[2]  = '{32'hB400009F, 64'd8,  7'b0000100, 2'b01, 5'd31, 64'd0,  64'd0,  1'b1, 64'd24};
        vecs[3]  = '{32'hCB040146, 64'd12, 7'b1000000, 2'b10, 5'd6,  64'd4,  64'd6,  1'b0, 64'd12};
        vecs[4]  = '{32'hCB020027, 64'd16, 7'b1000000, 2'b10, 5'd7,  64'd2,  64'hFFFFFFFFFFFFFFFF, 1'b0, 64'd16};
        vecs[5]  = '{32'h8A0A0188, 64'd20, 7'b1000000, 2'b10, 5'd8,  64'd10, 64'd8,  1'b0, 64'd20};
        vecs[6]  = '{32'hAA030189, 64'd24, 7'b1000000, 2'b10, 5'd9,  64'd3,  64'd15, 1'b0, 64'd24};
        vecs[7]  = '{32'hF81F8094, 64'd28, 7'b0010001, 2'b00, 5'd20, 64'd20, 64'hFFFFFFFFFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC};
        vecs[8]  = '{32'h17FFFFF8, 64'd32, 7'b0000010, 2'b00, 5'd24, 64'd24, 64'd24, 1'b0, 64'd0};
        vecs[9]  = '{32'h00000000, 64'd36, 7'b0000000, 2'b00, 5'd0,  64'd0,  64'd0,  1'b1, 64'd36};
        vecs[10] = '{32'hB4FFFFE1, 64'd40, 7'b0000100, 2'b01, 5'd1,  64'd1,  64'd1,  1'b0, 64'd36};
        vecs[11] = '{32'hD2800043, 64'd44, 7'b0000000, 2'b00, 5'd3,  64'd3,  64'd5,  1'b0, 64'd44};

        reset = 1'b0;
        pc_src = 1'b0;
        imem_we = 1'b0;
        imem_addr = '0;
        imem_wdata = '0;
        write_data = '0;
        write_register_in = '0;
        reg_write_in = 1'b0;

        // Reset state and sequential PC advance
        #2;
        chk("reset_pc", cur_pc, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(); chk("pc_4", cur_pc, 64'd4);
        step(); chk("pc_8", cur_pc, 64'd8);
        step(); chk("pc_12", cur_pc, 64'd12);

        // Load program under reset so the PC stays parked
        reset = 1'b0;
        for (int i = 0; i < 64; i++) load(i, 32'h0);
        for (int i = 0; i < 12; i++) load(i, vecs[i].instr);
        #2;
        reset = 1'b1;

        // Table walk, no write-back activity
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("v%0d_pc", i), cur_pc, vecs[i].pc);
            chk($sformatf("v%0d_instr", i), 64'(instruction), 64'(vecs[i].instr));
            chk($sformatf("v%0d_ctrl", i), 64'(ctrl_now()), 64'(vecs[i].ctrl));
            chk($sformatf("v%0d_aluop", i), 64'(alu_op), 64'(vecs[i].op));
            chk($sformatf("v%0d_wr", i), 64'(write_register_out), 64'(vecs[i].wr));
            chk($sformatf("v%0d_rd2", i), read_data2, vecs[i].rd2);
            chk($sformatf("v%0d_alu", i), alu_result, vecs[i].alu);
            chk($sformatf("v%0d_zero", i), 64'(zero), 64'(vecs[i].z));
            chk($sformatf("v%0d_bt", i), branch_target, vecs[i].bt);
            step();
        end

        // Write-back to X1 with write-through, then persistence after the edge
        reset = 1'b0;
        #2;
        reset = 1'b1;
        chk("wb_pc0", cur_pc, 64'd0);
        write_register_in = 5'd1;
        write_data = 64'h55;
        reg_write_in = 1'b1;
        #1;
        chk("wb_through", alu_result, 64'h57);
        imem_we = 1'b1;
        imem_addr = 6'd1;
        imem_wdata = 32'h8B020023;
        step();
        imem_we = 1'b0;
        reg_write_in = 1'b0;
        write_data = 64'h0;
        #1;
        chk("wb_persist_pc", cur_pc, 64'd4);
        chk("wb_persist", alu_result, 64'h57);
        chk("imem_write_now", 64'(instruction), 64'h8B020023);

        // Write to XZR while CBZ XZR is current, and take the branch
        imem_we = 1'b1;
        imem_wdata = 32'hF8408045;
        step();
        imem_we = 1'b0;
        chk("cbz_pc", cur_pc, 64'd8);
        write_register_in = 5'd31;
        write_data = 64'd7;
        reg_write_in = 1'b1;
        #1;
        chk("xzr_through", alu_result, 64'd0);
        chk("xzr_zero", 64'(zero), 64'd1);
        chk("cbz_target", branch_target, 64'd24);
        pc_src = 1'b1;
        step();
        pc_src = 1'b0;
        reg_write_in = 1'b0;
        chk("taken_pc", cur_pc, 64'd24);
        chk("taken_orr", alu_result, 64'd15);
        step();
        step();
        chk("b_pc", cur_pc, 64'd32);
        chk("xzr_persist", alu_result, 64'd24);

        // Asynchronous reset mid-run
        #2;
        reset = 1'b0;
        #1;
        chk("async_pc", cur_pc, 64'd0);
        chk("async_x1", alu_result, 64'd3);
        chk("async_instr", 64'(instruction), 64'h8B020023);
        #3;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset = 1'b1;

        // Fetch beyond the end of instruction memory reads a NOP
        for (int i = 0; i < 64; i++) step();
        chk("oob_pc", cur_pc, 64'd256);
        chk("oob_instr", 64'(instruction), 64'd0);
        chk("oob_ctrl", 64'(ctrl_now()), 64'd0);
        step();
        chk("oob_instr2", 64'(instruction), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
